mem_port_arbiter: RTL

//   Shares one fixed-latency unified memory port between the instruction-fetch requester (I) and the

---
 rtl/mem_port_arbiter_pkg.sv | 36 +++
 rtl/mem_port_arbiter_if.sv | 47 ++++
 rtl/mem_port_arbiter_wait_counter.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared access-mode encodings, arbiter state and owner types,
//               and counter-width helper for the I/D memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    // Access size/sign encodings shared with the data memory and the core
    localparam logic [2:0] MODE_BYTE   = 3'b000;
    localparam logic [2:0] MODE_HALF   = 3'b001;
    localparam logic [2:0] MODE_WORD   = 3'b010;
    localparam logic [2:0] MODE_BYTE_U = 3'b100;
    localparam logic [2:0] MODE_HALF_U = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // Bits needed to hold the values 0..max_value (never less than one bit)
    function automatic int cnt_width(input int max_value);
        return (max_value < 2) ? 1 : $clog2(max_value + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Fetch, load/store and unified memory port signals bundled for
//               the arbiter. master = core/memory side, slave = arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [2:0]        d_mode;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              m_req;
    logic              m_we;
    logic [2:0]        m_mode;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    modport master (
        output i_req, i_addr, d_req, d_we, d_mode, d_addr, d_wdata, m_rdata,
        input  i_ack, i_rvalid, i_rdata, d_ack, d_rvalid, d_rdata,
        input  m_req, m_we, m_mode, m_addr, m_wdata
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_mode, d_addr, d_wdata, m_rdata,
        output i_ack, i_rvalid, i_rdata, d_ack, d_rvalid, d_rdata,
        output m_req, m_we, m_mode, m_addr, m_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_wait_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_wait_counter
// Description : Memory latency counter. Loads 1 on the issue cycle, counts up
//               while waiting and flags terminal count at MEM_LATENCY.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wait_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LATENCY = 2
) (
    input  wire  clk,
    input  wire  reset,
    input  wire  i_load,
    input  wire  i_inc,
    output logic o_tc
);
    localparam int               CNT_W  = cnt_width(MEM_LATENCY);
    localparam logic [CNT_W-1:0] c_TERM = CNT_W'(MEM_LATENCY);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    // Load on issue, increment while waiting, never run past terminal count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= c_ONE;
        end else if (i_inc && (r_count != c_TERM)) begin
            r_count <= r_count + c_ONE;
        end
    end

    assign o_tc = (r_count == c_TERM);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one fixed-latency memory port between instruction
//               fetch (I) and load/store (D). D has priority unless I has
//               been passed over STARVE_LIMIT times in a row.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  wire               clk,
    input  wire               reset,
    mem_port_arbiter_if.slave bus
);
    localparam int               STV_W        = cnt_width(STARVE_LIMIT);
    localparam logic [STV_W-1:0] c_STARVE_MAX = STV_W'(STARVE_LIMIT);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    owner_t            r_owner;
    logic              r_we;
    logic [2:0]        r_mode;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic [STV_W-1:0]  r_starve;

    logic w_any_req;
    logic w_pick_d;
    logic w_arbitrate;
    logic w_capture;
    logic w_cnt_load;
    logic w_cnt_inc;
    logic w_cnt_tc;

    // D wins unless I is pending and has already lost STARVE_LIMIT times
    assign w_any_req   = bus.i_req | bus.d_req;
    assign w_pick_d    = bus.d_req & ~(bus.i_req & (r_starve == c_STARVE_MAX));
    assign w_arbitrate = (r_state == ST_IDLE) & w_any_req;
    assign w_capture   = (r_state == ST_WAIT) & w_cnt_tc;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and latency counter control
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_load  = 1'b0;
        w_cnt_inc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_cnt_load  = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_cnt_tc) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    mem_wait_counter #(
        .MEM_LATENCY (MEM_LATENCY)
    ) u_wait_cnt (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_cnt_load),
        .i_inc  (w_cnt_inc),
        .o_tc   (w_cnt_tc)
    );

    // Latch the winner's request, track starvation, capture returned data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner   <= OWN_I;
            r_we      <= 1'b0;
            r_mode    <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            r_starve  <= '0;
        end else begin
            if (w_arbitrate) begin
                if (w_pick_d) begin
                    r_owner <= OWN_D;
                    r_we    <= bus.d_we;
                    r_mode  <= bus.d_mode;
                    r_addr  <= bus.d_addr;
                    r_wdata <= bus.d_wdata;
                end else begin
                    r_owner <= OWN_I;
                    r_we    <= 1'b0;
                    r_mode  <= MODE_WORD;
                    r_addr  <= bus.i_addr;
                    r_wdata <= '0;
                end
                // Only a D win over a waiting fetch counts toward starvation
                if (!bus.i_req || !w_pick_d) begin
                    r_starve <= '0;
                end else if (r_starve != c_STARVE_MAX) begin
                    r_starve <= r_starve + STV_W'(1);
                end
            end
            if (w_capture) begin
                if (r_owner == OWN_I) begin
                    r_i_rdata <= bus.m_rdata;
                end else begin
                    r_d_rdata <= r_we ? '0 : bus.m_rdata;
                end
            end
        end
    end

    // Strobes decode from state; memory fields stay stable for the whole access
    assign bus.m_req    = (r_state == ST_ISSUE);
    assign bus.i_ack    = (r_state == ST_ISSUE) & (r_owner == OWN_I);
    assign bus.d_ack    = (r_state == ST_ISSUE) & (r_owner == OWN_D);
    assign bus.i_rvalid = (r_state == ST_DONE)  & (r_owner == OWN_I);
    assign bus.d_rvalid = (r_state == ST_DONE)  & (r_owner == OWN_D);
    assign bus.m_we     = r_we & (r_state != ST_IDLE);
    assign bus.m_mode   = r_mode;
    assign bus.m_addr   = r_addr;
    assign bus.m_wdata  = r_wdata;
    assign bus.i_rdata  = r_i_rdata;
    assign bus.d_rdata  = r_d_rdata;

endmodule
`default_nettype wire
